// File: rtl/io_pkg.sv
// io_pkg: shared address map, frame FSM encoding and latch width for the I/O port unit.
package io_pkg;
  localparam int NUM_OUT = 8;
  localparam logic [3:0] ADDR_OUT_BASE = 4'd0;
  localparam logic [3:0] ADDR_SCR_BASE = 4'd8;
  localparam logic [3:0] ADDR_COMMIT = 4'd14;
  localparam logic [3:0] ADDR_STATUS = 4'd15;
  typedef enum logic {IDLE = 1'b0, PEND = 1'b1} frame_state_t;
endpackage

// File: rtl/bit_sync.sv
// bit_sync: STAGES-deep flop chain per bit for asynchronous inputs, synchronous reset.
module bit_sync #(
  parameter int WIDTH = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [STAGES-1:0][WIDTH-1:0] stg;
  always_ff @(posedge clk)
    if (rst) stg <= '0;
    else stg <= {stg[STAGES-2:0], d};
  assign q = stg[STAGES-1];
endmodule

// File: rtl/io_port_unit.sv
// io_port_unit: output/scratch latches, synced input reads and a committed frame handshake.
// Define IO_READBACK_EN to make reads at addresses 0-7 return the output latches.
import io_pkg::*;
module io_port_unit #(
  parameter int NUM_OUT = io_pkg::NUM_OUT,
  parameter int NUM_SCRATCH = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         addr,
  input  logic               write,
  input  logic               result,
  output logic               data,
  input  logic [7:0]         in_pins,
  output logic [NUM_OUT-1:0] out_pins,
  output logic               frame_valid,
  input  logic               frame_ready,
  output logic [NUM_OUT-1:0] frame_data,
  output logic               overflow
);
  frame_state_t state;
  logic [NUM_SCRATCH-1:0] scratch;
  logic [7:0] sync_in;
  logic [NUM_OUT-1:0] low_src;
  logic commit;
  bit_sync #(.WIDTH(8), .STAGES(SYNC_STAGES)) u_sync (
    .clk(clk),
    .rst(rst),
    .d(in_pins),
    .q(sync_in)
  );
  assign commit = write && addr == ADDR_COMMIT && result;
`ifdef IO_READBACK_EN
  assign low_src = out_pins;
`else
  assign low_src = sync_in;
`endif
  always_comb
    data = addr < ADDR_SCR_BASE ? low_src[addr[2:0]] :
           addr == ADDR_COMMIT ? frame_valid :
           addr == ADDR_STATUS ? overflow : scratch[addr[2:0]];
  always_ff @(posedge clk)
    if (rst) begin
      out_pins <= '0;
      scratch <= '0;
      state <= IDLE;
      frame_valid <= 1'b0;
      frame_data <= '0;
      overflow <= 1'b0;
    end else begin
      if (write && addr < ADDR_SCR_BASE) out_pins[addr[2:0]] <= result;
      if (write && addr >= ADDR_SCR_BASE && addr < ADDR_COMMIT) scratch[addr[2:0]] <= result;
      if (state == IDLE) begin
        if (commit) begin
          frame_data <= out_pins;
          frame_valid <= 1'b1;
          state <= PEND;
        end
      end else if (commit) begin
        // a commit landing on the accept edge replaces the retiring frame
        if (frame_ready) frame_data <= out_pins;
        else overflow <= 1'b1;
      end else if (frame_ready) begin
        frame_valid <= 1'b0;
        state <= IDLE;
      end
    end
endmodule
